// File: rtl/range_pkg.sv
// Shared types for the range-finder frame sequencer.
// Holds FSM encodings, default sizing and the buffer entry layout.
package range_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;

  typedef enum logic {
    WR_ACCEPT,
    WR_DISCARD
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_EMIT
  } rd_state_t;

  typedef struct packed {
    logic                 last;
    logic [DEF_WIDTH-1:0] data;
  } entry_t;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO with wrap-bit pointers and a flush input.
// Read data is presented combinationally from the head entry.
module sample_fifo
  import range_pkg::*;
#(
  parameter int W     = DEF_WIDTH + 1,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  input  logic         flush,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/range_frame_sequencer.sv
// Buffers whole input frames and replays each as a gap-free burst.
// Oversize frames are flushed and the rest of the frame discarded.
module range_frame_sequencer
  import range_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             go,
  output logic             finish,
  output logic             busy,
  output logic             overflow
);

  localparam int PW = $clog2(DEPTH + 1);

  wr_state_t     wr_state;
  wr_state_t     wr_next;
  rd_state_t     rd_state;
  rd_state_t     rd_next;
  logic [PW-1:0] pending;
  logic [PW-1:0] pending_nxt;
  logic          first_q;

  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_flush;
  logic          fifo_full;
  logic          fifo_empty;
  logic [WIDTH:0] fifo_rdata;

  logic          accept;
  logic          pend_inc;
  logic          pend_dec;

  sample_fifo #(
    .W     (WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata ({in_last, in_data}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .flush (fifo_flush),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign in_ready = (wr_state == WR_DISCARD) || !fifo_full;
  assign accept   = in_valid && in_ready;

  assign fifo_push  = accept && (wr_state == WR_ACCEPT);
  assign fifo_flush = (wr_state == WR_ACCEPT) && fifo_full &&
                      (pending == '0);
  assign fifo_pop   = (rd_state == RD_EMIT) && !fifo_empty;

  assign pend_inc    = fifo_push && in_last;
  assign pend_dec    = fifo_pop && fifo_rdata[WIDTH];
  assign pending_nxt = pending + PW'(pend_inc) - PW'(pend_dec);

  always_comb begin
    wr_next = wr_state;
    rd_next = rd_state;
    unique case (1'b1)
      wr_state == WR_ACCEPT:
        if (fifo_flush) wr_next = WR_DISCARD;
      wr_state == WR_DISCARD:
        if (accept && in_last) wr_next = WR_ACCEPT;
      default: wr_next = WR_ACCEPT;
    endcase
    unique case (1'b1)
      rd_state == RD_IDLE:
        if (pending != '0) rd_next = RD_EMIT;
      rd_state == RD_EMIT:
        if (pend_dec && pending_nxt == '0) rd_next = RD_IDLE;
      default: rd_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state <= WR_ACCEPT;
      rd_state <= RD_IDLE;
      pending  <= '0;
      first_q  <= 1'b1;
      overflow <= 1'b0;
    end else begin
      wr_state <= wr_next;
      rd_state <= rd_next;
      pending  <= pending_nxt;
      overflow <= fifo_flush;
      // next pop opens a new frame after idle or a finish
      first_q  <= (rd_state == RD_IDLE) || pend_dec;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
      go       <= 1'b0;
      finish   <= 1'b0;
      busy     <= 1'b0;
    end else if (fifo_pop) begin
      data_out <= fifo_rdata[WIDTH-1:0];
      go       <= first_q;
      finish   <= fifo_rdata[WIDTH];
      busy     <= 1'b1;
    end else begin
      data_out <= '0;
      go       <= 1'b0;
      finish   <= 1'b0;
      busy     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_range_frame_sequencer.sv
// Directed bench for range_frame_sequencer: frame table plus
// hand-written overflow, backpressure and reset sequences.
module tb_range_frame_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic [7:0] data_out;
  logic       go;
  logic       finish;
  logic       busy;
  logic       overflow;

  range_frame_sequencer #(
    .WIDTH (8),
    .DEPTH (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .data_out (data_out),
    .go       (go),
    .finish   (finish),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int len;
    int din[4];
    int dexp[4];
  } vec_t;

  typedef struct {
    int   cyc;
    logic go;
    logic fin;
    int   data;
  } obs_t;

  vec_t vecs[4];
  obs_t log_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   ovf_hi = 0;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (busy) log_q.push_back('{cyc, go, finish, int'(data_out)});
    if (overflow) ovf_hi++;
  end

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push(input int d, input bit l, output int st);
    st = 0;
    in_valid = 1'b1;
    in_data = 8'(d);
    in_last = l;
    while (!in_ready && st < 40) begin
      @(negedge clk);
      st++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic chk_entry(input string nm, input int idx, input int c0,
                           input int d, input bit g, input bit f);
    chk({nm, "_present"}, int'(log_q.size() > idx), 1);
    if (log_q.size() > idx) begin
      chk({nm, "_data"}, log_q[idx].data, d);
      chk({nm, "_go"}, int'(log_q[idx].go), int'(g));
      chk({nm, "_fin"}, int'(log_q[idx].fin), int'(f));
      chk({nm, "_cyc"}, log_q[idx].cyc, c0 + idx);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int st;
    int ssum;
    int o0;
    int c0;

    vecs[0].len = 3; vecs[0].din = '{10, 40, 25, 0};
    vecs[0].dexp = '{10, 40, 25, 0};
    vecs[1].len = 1; vecs[1].din = '{8'h7F, 0, 0, 0};
    vecs[1].dexp = '{127, 0, 0, 0};
    vecs[2].len = 2; vecs[2].din = '{1, 2, 0, 0};
    vecs[2].dexp = '{1, 2, 0, 0};
    vecs[3].len = 4; vecs[3].din = '{0, 8'hFF, 8'h80, 1};
    vecs[3].dexp = '{0, 255, 128, 1};

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_data", int'(data_out), 0);
    chk("rst_go", int'(go), 0);
    chk("rst_finish", int'(finish), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_in_ready", int'(in_ready), 1);

    foreach (vecs[v]) begin
      ssum = 0;
      for (int i = 0; i < vecs[v].len; i++) begin
        push(vecs[v].din[i], i == vecs[v].len - 1, st);
        ssum += st;
      end
      chk("vec_stalls", ssum, 0);
      @(negedge clk);
      chk("vec_busy_early", int'(busy), 0);
      chk("vec_go_early", int'(go), 0);
      @(negedge clk);
      for (int i = 0; i < vecs[v].len; i++) begin
        chk("vec_data", int'(data_out), vecs[v].dexp[i]);
        chk("vec_go", int'(go), int'(i == 0));
        chk("vec_finish", int'(finish), int'(i == vecs[v].len - 1));
        chk("vec_busy", int'(busy), 1);
        @(negedge clk);
      end
      chk("vec_busy_end", int'(busy), 0);
      chk("vec_data_end", int'(data_out), 0);
      repeat (2) @(negedge clk);
    end

    // back-to-back frames {1,2} and {3,4}
    log_q.delete();
    push(1, 0, st); push(2, 1, st); push(3, 0, st); push(4, 1, st);
    repeat (8) @(negedge clk);
    chk("b2b_count", log_q.size(), 4);
    c0 = (log_q.size() > 0) ? log_q[0].cyc : 0;
    chk_entry("b2b0", 0, c0, 1, 1, 0);
    chk_entry("b2b1", 1, c0, 2, 0, 1);
    chk_entry("b2b2", 2, c0, 3, 1, 0);
    chk_entry("b2b3", 3, c0, 4, 0, 1);

    // 17-sample frame overflows, then {5,6}
    log_q.delete();
    o0 = ovf_hi;
    ssum = 0;
    for (int i = 0; i < 16; i++) begin
      push(50 + i, 0, st);
      ssum += st;
    end
    chk("ovf_fill_stalls", ssum, 0);
    chk("ovf_not_yet", int'(overflow), 0);
    chk("ovf_full_ready", int'(in_ready), 0);
    @(negedge clk);
    chk("ovf_pulse", int'(overflow), 1);
    chk("ovf_discard_ready", int'(in_ready), 1);
    push(99, 1, st);
    chk("ovf_discard_stall", st, 0);
    chk("ovf_pulse_gone", int'(overflow), 0);
    push(5, 0, st);
    push(6, 1, st);
    repeat (6) @(negedge clk);
    chk("ovf_pulse_count", ovf_hi - o0, 1);
    chk("ovf_out_count", log_q.size(), 2);
    c0 = (log_q.size() > 0) ? log_q[0].cyc : 0;
    chk_entry("ovf0", 0, c0, 5, 1, 0);
    chk_entry("ovf1", 1, c0, 6, 0, 1);

    // full buffer with a complete frame: backpressure
    log_q.delete();
    ssum = 0;
    for (int i = 0; i < 16; i++) begin
      push(100 + i, i == 15, st);
      ssum += st;
    end
    for (int i = 0; i < 4; i++) begin
      push(200 + i, i == 3, st);
      ssum += st;
    end
    chk("bp_stalls", ssum, 2);
    repeat (22) @(negedge clk);
    chk("bp_count", log_q.size(), 20);
    c0 = (log_q.size() > 0) ? log_q[0].cyc : 0;
    for (int i = 0; i < 16; i++)
      chk_entry("bp_a", i, c0, 100 + i, i == 0, i == 15);
    for (int i = 0; i < 4; i++)
      chk_entry("bp_b", 16 + i, c0, 200 + i, i == 0, i == 3);

    // reset during a 5-sample emission
    log_q.delete();
    for (int i = 0; i < 5; i++) push(11 + i, i == 4, st);
    repeat (3) @(negedge clk);
    chk("mr_pre_data", int'(data_out), 12);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_data", int'(data_out), 0);
    chk("mr_go", int'(go), 0);
    chk("mr_finish", int'(finish), 0);
    chk("mr_busy", int'(busy), 0);
    chk("mr_overflow", int'(overflow), 0);
    chk("mr_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("mr_count", log_q.size(), 2);
    c0 = (log_q.size() > 0) ? log_q[0].cyc : 0;
    chk_entry("mr0", 0, c0, 11, 1, 0);
    chk_entry("mr1", 1, c0, 12, 0, 0);
    chk("mr_ready_after", int'(in_ready), 1);
    log_q.delete();
    push(9, 0, st);
    push(8, 1, st);
    repeat (5) @(negedge clk);
    chk("mr_new_count", log_q.size(), 2);
    c0 = (log_q.size() > 0) ? log_q[0].cyc : 0;
    chk_entry("mr_new0", 0, c0, 9, 1, 0);
    chk_entry("mr_new1", 1, c0, 8, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
